// File: rtl/gauss_filter.sv
// Streaming 3x3 Gaussian blur over an RGB444 frame buffer.
// Sequential reads, two line buffers, a 3x3 window and one registered write per pixel.
module gauss_filter #(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int ADDR_W = 18,
   parameter int PIX_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] RdAddr,
   input  logic [PIX_W-1:0]  RdDout,
   output logic [PIX_W-1:0]  GaussDin,
   output logic              GaussWea,
   output logic [ADDR_W-1:0] GaussAddr
);

   localparam int N  = IMG_W * IMG_H;
   localparam int XW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int FW = $clog2(IMG_W + 3);
   localparam int NCH = PIX_W / 4;

   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N - 1);
   localparam logic [FW-1:0]     FL_INJ = FW'(IMG_W + 1);
   localparam logic [FW-1:0]     FL_END = FW'(IMG_W + 2);
   localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      FLUSH,
      DONE
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [FW-1:0]     fl_cnt_q;
   logic              busy_q;
   logic              done_q;
   logic              iss_q;
   logic              iss_zero_q;
   logic [XW-1:0]     ptr_q;
   logic [FW-1:0]     pcnt_q;
   logic [XW-1:0]     jx_q;
   logic [YW-1:0]     jy_q;
   logic [ADDR_W-1:0] j_q;
   logic              wea_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [PIX_W-1:0]  wdin_q;

   logic [PIX_W-1:0]  lb0_q [IMG_W];
   logic [PIX_W-1:0]  lb1_q [IMG_W];
   logic [PIX_W-1:0]  win_q [3][3];

   logic [PIX_W-1:0]  pix_in_d;
   logic [PIX_W-1:0]  col_t_d;
   logic [PIX_W-1:0]  col_m_d;
   logic [PIX_W-1:0]  win_d [3][3];
   logic [PIX_W-1:0]  blur_d;
   logic [PIX_W-1:0]  wdin_d;
   logic              border_d;
   logic [7:0]        acc_d;
   logic [7:0]        term_d;
   logic [1:0]        sh_d;

   assign busy      = busy_q;
   assign done      = done_q;
   assign RdAddr    = rd_addr_q;
   assign GaussDin  = wdin_q;
   assign GaussWea  = wea_q;
   assign GaussAddr = waddr_q;

   // New column: two lines back, one line back, current input
   always_comb begin
      pix_in_d = iss_zero_q ? '0 : RdDout;
      col_t_d  = lb1_q[ptr_q];
      col_m_d  = lb0_q[ptr_q];
      for (int r = 0; r < 3; r++) begin
         win_d[r][0] = win_q[r][1];
         win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = col_t_d;
      win_d[1][2] = col_m_d;
      win_d[2][2] = pix_in_d;
   end

   always_comb begin
      blur_d = '0;
      acc_d  = '0;
      term_d = '0;
      sh_d   = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         acc_d = 8'd8;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               sh_d   = 2'(r == 1) + 2'(c == 1);
               term_d = {4'd0, win_d[r][c][ch*4 +: 4]} << sh_d;
               acc_d  = acc_d + term_d;
            end
         end
         blur_d[ch*4 +: 4] = acc_d[7:4];
      end
   end

   always_comb begin
      border_d = (jx_q == '0) || (jx_q == X_LAST) ||
                 (jy_q == '0) || (jy_q == Y_LAST);
      wdin_d   = border_d ? win_q[1][2] : blur_d;
   end

   always_ff @(posedge clk) begin
      if (iss_q) begin
         lb1_q[ptr_q] <= col_m_d;
         lb0_q[ptr_q] <= pix_in_d;
         win_q        <= win_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_addr_q  <= '0;
         fl_cnt_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         iss_q      <= 1'b0;
         iss_zero_q <= 1'b0;
         ptr_q      <= '0;
         pcnt_q     <= '0;
         jx_q       <= '0;
         jy_q       <= '0;
         j_q        <= '0;
         wea_q      <= 1'b0;
         waddr_q    <= '0;
         wdin_q     <= '0;
      end else begin
         iss_q      <= 1'b0;
         iss_zero_q <= 1'b0;
         done_q     <= 1'b0;
         wea_q      <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= READ;
                  busy_q    <= 1'b1;
                  rd_addr_q <= '0;
                  fl_cnt_q  <= '0;
                  pcnt_q    <= '0;
                  jx_q      <= '0;
                  jy_q      <= '0;
                  j_q       <= '0;
               end
            end
            READ: begin
               iss_q <= 1'b1;
               if (rd_addr_q == LAST) begin
                  state_q <= FLUSH;
               end else begin
                  rd_addr_q <= rd_addr_q + 1'b1;
               end
            end
            FLUSH: begin
               if (fl_cnt_q < FL_INJ) begin
                  iss_q      <= 1'b1;
                  iss_zero_q <= 1'b1;
               end
               // two extra cycles let the last pixel leave the output register
               if (fl_cnt_q == FL_END) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  fl_cnt_q <= fl_cnt_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         if (iss_q) begin
            ptr_q <= (ptr_q == X_LAST) ? '0 : ptr_q + 1'b1;
            if (pcnt_q != FL_INJ) begin
               pcnt_q <= pcnt_q + 1'b1;
            end else begin
               wea_q   <= 1'b1;
               waddr_q <= j_q;
               wdin_q  <= wdin_d;
               j_q     <= j_q + 1'b1;
               if (jx_q == X_LAST) begin
                  jx_q <= '0;
                  jy_q <= jy_q + 1'b1;
               end else begin
                  jx_q <= jx_q + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gauss_filter.sv
// Bench for gauss_filter: frame memory model, reference blur and
// a write scoreboard drained by an independent monitor.
module tb_gauss_filter;

   localparam int W  = 7;
   localparam int H  = 5;
   localparam int N  = W * H;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic [AW-1:0] RdAddr;
   logic [11:0]   RdDout;
   logic [11:0]   GaussDin;
   logic          GaussWea;
   logic [AW-1:0] GaussAddr;

   logic [11:0]   mem [N];
   logic [11:0]   img [N];
   logic          load;

   int            n_chk  = 0;
   int            n_fail = 0;
   int            exp_addr_q [$];
   logic [11:0]   exp_dat_q  [$];

   gauss_filter #(
      .IMG_W (W),
      .IMG_H (H),
      .ADDR_W(AW),
      .PIX_W (12)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .RdAddr   (RdAddr),
      .RdDout   (RdDout),
      .GaussDin (GaussDin),
      .GaussWea (GaussWea),
      .GaussAddr(GaussAddr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load) begin
         mem <= img;
      end else begin
         RdDout <= mem[int'(RdAddr) % N];
         if (GaussWea === 1'b1) mem[int'(GaussAddr) % N] <= GaussDin;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] ref_pix(input int x, input int y);
      logic [11:0] o;
      int s;
      if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return img[y*W + x];
      o = '0;
      for (int ch = 0; ch < 3; ch++) begin
         s = 8;
         for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
               s += (2 - (dx < 0 ? -dx : dx)) * (2 - (dy < 0 ? -dy : dy)) *
                    int'(img[(y + dy)*W + x + dx][ch*4 +: 4]);
            end
         end
         o[ch*4 +: 4] = 4'(s / 16);
      end
      return o;
   endfunction

   task automatic push_expected();
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            exp_addr_q.push_back(y*W + x);
            exp_dat_q.push_back(ref_pix(x, y));
         end
      end
   endtask

   always @(negedge clk) begin
      if (GaussWea === 1'b1) begin
         if (exp_addr_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data %0h", GaussAddr, GaussDin);
         end else begin
            check("wr_addr", 32'(GaussAddr), 32'(exp_addr_q.pop_front()));
            check("wr_data", 32'(GaussDin), 32'(exp_dat_q.pop_front()));
         end
      end
   end

   task automatic load_and_start();
      push_expected();
      @(posedge clk); #1 load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("busy_after_start", 32'(busy), 32'd1);
      check("rdaddr_first", 32'(RdAddr), 32'd0);
   endtask

   task automatic run_frame(input bit mid_start);
      int c, first_c, last_c, done_c, wr, idle_bad;
      load_and_start();
      c = 1; first_c = -1; last_c = -1; done_c = -1; wr = 0;
      while (done_c < 0 && c < N + W + 60) begin
         if (GaussWea === 1'b1) begin
            wr++;
            if (first_c < 0) first_c = c;
            last_c = c;
         end
         if (done === 1'b1) begin
            done_c = c;
            check("busy_in_done", 32'(busy), 32'd0);
         end
         start = mid_start && (c == 12);
         if (done_c < 0) begin
            @(negedge clk);
            c++;
         end
      end
      start = 1'b0;
      if (done_c < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", c);
      end
      check("first_write_cycle", 32'(first_c), 32'(W + 4));
      check("write_count", 32'(wr), 32'(N));
      check("done_latency", 32'(done_c - last_c), 32'd1);
      check("scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);
      check("rdaddr_hold", 32'(RdAddr), 32'(N - 1));
      idle_bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0) idle_bad++;
      end
      check("idle_after_done", 32'(idle_bad), 32'd0);
   endtask

   initial begin
      int bad;
      rst = 1'b1; start = 1'b0; load = 1'b0;
      for (int k = 0; k < N; k++) img[k] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wea", 32'(GaussWea), 32'd0);
      check("rst_rdaddr", 32'(RdAddr), 32'd0);
      check("rst_waddr", 32'(GaussAddr), 32'd0);
      check("rst_wdin", 32'(GaussDin), 32'd0);
      rst = 1'b0;

      for (int k = 0; k < N; k++) img[k] = 12'hABC;
      run_frame(1'b0);

      for (int k = 0; k < N; k++) img[k] = '0;
      img[2*W + 3] = 12'hF00;
      run_frame(1'b0);
      check("impulse_center", 32'(mem[2*W + 3]), 32'h400);
      check("impulse_left", 32'(mem[2*W + 2]), 32'h200);
      check("impulse_right", 32'(mem[2*W + 4]), 32'h200);
      check("impulse_up", 32'(mem[1*W + 3]), 32'h200);
      check("impulse_diag", 32'(mem[1*W + 2]), 32'h100);
      check("impulse_far", 32'(mem[2*W + 5]), 32'h000);

      for (int k = 0; k < N; k++) img[k] = 12'($urandom);
      run_frame(1'b1);

      for (int k = 0; k < N; k++) img[k] = 12'($urandom);
      run_frame(1'b0);

      for (int k = 0; k < N; k++) img[k] = 12'($urandom);
      load_and_start();
      repeat (19) @(negedge clk);
      #2 rst = 1'b1;
      exp_addr_q.delete();
      exp_dat_q.delete();
      @(negedge clk);
      check("rst_mid_wea", 32'(GaussWea), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (GaussWea !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("quiet_after_rst", 32'(bad), 32'd0);

      for (int k = 0; k < N; k++) img[k] = 12'($urandom);
      run_frame(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
